reg_scoreboard: RTL
===================

# reg_scoreboard

Register-hazard scoreboard for the RISC-V core pipeline, placed between decode/issue and the register file write-back path. It tracks destination registers of outstanding long-latency operations (loads, multi-cycle ALU ops) in an in-order tag queue and holds a busy bit per architectural register. It stalls issue on RAW/WAW hazards and full queue. On completion it supplies the destination tag the write-back stage uses to drive the register file write port.

## Interface
Parameters:
- NUM_REGS, 32, architectural registers; index 0 is hard-wired zero
- ADDR_W, 5, register index width
- MAX_PENDING, 4, depth of the outstanding-op tag queue (power of two)

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- issue_valid  input  1  decode presents an instruction
- issue_rs1, issue_rs2  input  ADDR_W  source register indices
- issue_uses_rs1, issue_uses_rs2  input  1  source actually read
- issue_writes_rd  input  1  instruction writes rd
- issue_rd  input  ADDR_W  destination index
- issue_long  input  1  write to rd completes later via complete_valid
- issue_stall  output  1  combinational; instruction must not fire this cycle
- complete_valid  input  1  oldest long op writes back this cycle
- head_valid  output  1  queue non-empty
- head_rd  output  ADDR_W  destination tag of oldest outstanding op (write-back address)
- busy  output  NUM_REGS  registered busy vector, bit 0 always 0
- pending_count  output  $clog2(MAX_PENDING)+1  queue occupancy
- err  output  1  sticky protocol error

## Operation
- fire = issue_valid & ~issue_stall.
- RAW hazard: uses_rsN & rsN!=0 & busy[rsN] & ~(complete_valid & head_valid & head_rd==rsN). Same-cycle completion bypasses because the register file forwards its write data to reads in the same cycle.
- WAW hazard: issue_writes_rd & rd!=0 & busy[rd], with the same completion bypass.
- Full hazard: issue_long & pending_count==MAX_PENDING & ~complete_valid. A completion in the same cycle frees a slot.
- issue_stall = issue_valid & (RAW | WAW | full). It is 0 when issue_valid=0.
- On fire with issue_long:
  - push issue_rd at the tail.
  - set busy[issue_rd] if rd!=0.
  - rd=0 still occupies a slot (tag 0) so completion ordering holds.
- On fire without issue_long: no state change. The short-latency write goes straight to the register file.
- complete_valid & head_valid: pop head and clear busy[head_rd].
- complete_valid & ~head_valid: set err, no other state change.
- Simultaneous pop and push: count unchanged. If the pushed rd equals the popped rd, set wins and busy stays 1. WAW stall prevents this except via the bypass path, which is legal.
- Pointers wrap modulo MAX_PENDING. count saturates never: push is only permitted when not full, or when full with a simultaneous pop.
- err clears only on rst.
- busy[0] is forced 0 regardless of writes.

## Timing
- Reset (rst high at edge): busy=0, pending_count=0, head_valid=0, head_rd=0, err=0, pointers=0. rst dominates issue/complete in the same cycle.
- issue_stall, head_rd, and head_valid are combinational from registered state plus current inputs. There is no path from issue_* to head_*.
- Fire at edge N: busy[rd] and pending_count visible after edge N.
- Completion at edge N: busy cleared after edge N. Dependent instructions may already fire in cycle N via the bypass.
- Minimum long-op occupancy is 1 cycle: issue at N, complete_valid in cycle N+1.
- rst mid-operation discards all pending tags. Later complete_valid with an empty queue raises err.

## Test plan
- Reset, then issue_long rd=5, next cycle issue_valid rs1=5 uses_rs1=1 → issue_stall=1, busy[5]=1, pending_count=1, head_rd=5.
- Same stalled instruction while complete_valid=1 → issue_stall=0 that cycle; after the edge busy[5]=0, pending_count=0, head_valid=0.
- Four issue_long to rd=1,2,3,4 → count=4, fifth issue_long stalls. Fifth with complete_valid=1 → fires, count stays 4, head_rd=2 after the edge, busy={4,3,2,new}.
- issue_long rd=0 → busy stays 0, count=1, head_rd=0. Reader of x0 never stalls. Completion pops, count=0.
- complete_valid with empty queue → err=1 and stays 1 through later traffic until rst.
- Fill 3 entries, assert rst with simultaneous issue_long and complete_valid → all outputs at reset values the next cycle.

Source files
------------

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: register-hazard scoreboard for the pipeline issue stage.
// Tracks destinations of outstanding long-latency ops in an in-order tag
// queue, keeps a busy bit per architectural register, stalls issue on
// RAW/WAW/full hazards and supplies the write-back destination tag.
module reg_scoreboard #(
  parameter int NUM_REGS    = 32,
  parameter int ADDR_W      = 5,
  parameter int MAX_PENDING = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           issue_valid,
  input  logic [ADDR_W-1:0]              issue_rs1,
  input  logic [ADDR_W-1:0]              issue_rs2,
  input  logic                           issue_uses_rs1,
  input  logic                           issue_uses_rs2,
  input  logic                           issue_writes_rd,
  input  logic [ADDR_W-1:0]              issue_rd,
  input  logic                           issue_long,
  output logic                           issue_stall,
  input  logic                           complete_valid,
  output logic                           head_valid,
  output logic [ADDR_W-1:0]              head_rd,
  output logic [NUM_REGS-1:0]            busy,
  output logic [$clog2(MAX_PENDING):0]   pending_count,
  output logic                           err
);

  localparam int PTR_W = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
  localparam int CNT_W = $clog2(MAX_PENDING) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_PENDING);

  logic [ADDR_W-1:0]   tag_q_r [MAX_PENDING];
  logic [PTR_W-1:0]    head_ptr_r;
  logic [PTR_W-1:0]    tail_ptr_r;
  logic [CNT_W-1:0]    count_r;
  logic [NUM_REGS-1:0] busy_r;
  logic                err_r;

  logic                head_valid_s;
  logic [ADDR_W-1:0]   head_rd_s;
  logic                pop_s;
  logic                push_s;
  logic                raw1_s;
  logic                raw2_s;
  logic                waw_s;
  logic                full_s;
  logic                stall_s;
  logic [NUM_REGS-1:0] busy_nxt_s;

  assign head_valid_s = (count_r != {CNT_W{1'b0}});
  assign head_rd_s    = tag_q_r[head_ptr_r];

  // Hazard detection; a completing head register is forwarded, so it does not stall.
  always_comb begin
    raw1_s  = 1'b0;
    raw2_s  = 1'b0;
    waw_s   = 1'b0;
    full_s  = 1'b0;
    pop_s   = complete_valid & head_valid_s;
    if (issue_uses_rs1 && (issue_rs1 != {ADDR_W{1'b0}}) && busy_r[issue_rs1] &&
        !(pop_s && (head_rd_s == issue_rs1))) begin
      raw1_s = 1'b1;
    end else begin
      raw1_s = 1'b0;
    end
    if (issue_uses_rs2 && (issue_rs2 != {ADDR_W{1'b0}}) && busy_r[issue_rs2] &&
        !(pop_s && (head_rd_s == issue_rs2))) begin
      raw2_s = 1'b1;
    end else begin
      raw2_s = 1'b0;
    end
    if (issue_writes_rd && (issue_rd != {ADDR_W{1'b0}}) && busy_r[issue_rd] &&
        !(pop_s && (head_rd_s == issue_rd))) begin
      waw_s = 1'b1;
    end else begin
      waw_s = 1'b0;
    end
    if (issue_long && (count_r == FULL_CNT) && !complete_valid) begin
      full_s = 1'b1;
    end else begin
      full_s = 1'b0;
    end
    stall_s = issue_valid & (raw1_s | raw2_s | waw_s | full_s);
    push_s  = issue_valid & ~stall_s & issue_long;
  end

  // Next busy vector: clear the completing tag first so a same-register push wins.
  always_comb begin
    busy_nxt_s = busy_r;
    if (pop_s) begin
      busy_nxt_s[head_rd_s] = 1'b0;
    end else begin
      busy_nxt_s = busy_r;
    end
    if (push_s && (issue_rd != {ADDR_W{1'b0}})) begin
      busy_nxt_s[issue_rd] = 1'b1;
    end else begin
      busy_nxt_s = busy_nxt_s;
    end
    busy_nxt_s[0] = 1'b0;
  end

  // Tag queue, pointers, occupancy, busy bits and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MAX_PENDING; i++) begin
        tag_q_r[i] <= {ADDR_W{1'b0}};
      end
      head_ptr_r <= {PTR_W{1'b0}};
      tail_ptr_r <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      busy_r     <= {NUM_REGS{1'b0}};
      err_r      <= 1'b0;
    end else begin
      if (push_s) begin
        tag_q_r[tail_ptr_r] <= issue_rd;
        tail_ptr_r          <= tail_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        head_ptr_r <= head_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
      busy_r <= busy_nxt_s;
      if (complete_valid && !head_valid_s) begin
        err_r <= 1'b1;
      end
    end
  end

  assign issue_stall   = stall_s;
  assign head_valid    = head_valid_s;
  assign head_rd       = head_rd_s;
  assign busy          = busy_r;
  assign pending_count = count_r;
  assign err           = err_r;

endmodule
